// File: rtl/neighbor_builder_if.sv
// ---------------------------------------------------------------------------
// neighbor_builder_if
// Groups the neighbor_builder control/status signals and both RAM buses.
//   master : the builder (drives RAM address/enable/data, busy and flags)
//   slave  : its environment (controller driving start/counts, RAM read data)
// Signals:
//   start, vertex_count, face_count        controller -> builder
//   busy, overflow, bad_index              builder -> controller
//   RAM_OBJ_EN/WE/A/Di, RAM_OBJ_Do         object RAM port
//   RAM_NBR_EN/WE/A/Di, RAM_NBR_Do         neighbour RAM port
// ---------------------------------------------------------------------------
interface neighbor_builder_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  start;
    logic [31:0]           vertex_count;
    logic [31:0]           face_count;
    logic                  busy;
    logic                  overflow;
    logic                  bad_index;

    logic                  RAM_OBJ_EN;
    logic [3:0]            RAM_OBJ_WE;
    logic [ADDR_WIDTH-1:0] RAM_OBJ_A;
    logic [31:0]           RAM_OBJ_Di;
    logic [31:0]           RAM_OBJ_Do;

    logic                  RAM_NBR_EN;
    logic [3:0]            RAM_NBR_WE;
    logic [ADDR_WIDTH-1:0] RAM_NBR_A;
    logic [31:0]           RAM_NBR_Di;
    logic [31:0]           RAM_NBR_Do;

    modport master (
        input  start, vertex_count, face_count, RAM_OBJ_Do, RAM_NBR_Do,
        output busy, overflow, bad_index,
               RAM_OBJ_EN, RAM_OBJ_WE, RAM_OBJ_A, RAM_OBJ_Di,
               RAM_NBR_EN, RAM_NBR_WE, RAM_NBR_A, RAM_NBR_Di
    );

    modport slave (
        output start, vertex_count, face_count, RAM_OBJ_Do, RAM_NBR_Do,
        input  busy, overflow, bad_index,
               RAM_OBJ_EN, RAM_OBJ_WE, RAM_OBJ_A, RAM_OBJ_Di,
               RAM_NBR_EN, RAM_NBR_WE, RAM_NBR_A, RAM_NBR_Di
    );
endinterface

// File: rtl/neighbor_builder.sv
// ---------------------------------------------------------------------------
// neighbor_builder
// Walks the face list in the object RAM and builds a per-vertex table of
// unique neighbour indices in the neighbour RAM. Vertex v owns the block at
// v*MAX_NEIGHBOR_COUNT: word 0 is the count, the following words hold
// 1-based neighbour indices in first-seen order.
// Ports:
//   clk  : clock; all state changes on the falling edge (RAMs use the rising)
//   rst  : asynchronous reset, active-high
//   bus  : neighbor_builder_if.master (start/counts, status, both RAM ports)
// Optional build macro:
//   NBR_RANGE_CHECK_EN : faces with an index of 0 or above vertex_count are
//                        skipped and flagged on bad_index; without it
//                        bad_index is tied low and indices are not checked.
// ---------------------------------------------------------------------------
module neighbor_builder #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH         = 11
) (
    input  logic               clk,
    input  logic               rst,
    neighbor_builder_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_FACE_RD, S_EDGE, S_CNT_RD,
        S_SCAN_RD, S_APPEND_WR, S_CNT_WR, S_DONE
    } state_t;

    localparam logic [31:0]           MAX_W = 32'(MAX_NEIGHBOR_COUNT);
    localparam logic [31:0]           SLOTS = MAX_W - 32'd1;
    localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(MAX_NEIGHBOR_COUNT);

    state_t                state, state_nxt;
    logic [31:0]           vidx, fidx, cnt, slot, wdata;
    logic [31:0]           va, vb, vc;
    logic [1:0]            sub, edge_sel;
    logic                  dir, ovf;
    logic [ADDR_WIDTH-1:0] addr, faddr, base;

    logic [31:0]           v_sel, n_sel, cnt_cur;
    logic [ADDR_WIDTH-1:0] base_nxt, face_base;
    logic                  face_bad, is_self, room, match, last_slot, last_face;
    logic                  do_advance, set_ovf, bump_edge, face_done;
    logic [3:0]            nbr_we;
    state_t                after_face, adv_state;

    // Current directed edge: v receives n. dir=0 takes (x<-y), dir=1 (y<-x).
    always_comb begin
        logic [31:0] x, y;
        x = va;
        y = vb;
        case (edge_sel)
            2'd1:    begin x = vb; y = vc; end
            2'd2:    begin x = vc; y = va; end
            default: begin x = va; y = vb; end
        endcase
        v_sel = dir ? y : x;
        n_sel = dir ? x : y;
    end

    assign base_nxt  = ADDR_WIDTH'((v_sel - 32'd1) * MAX_W);
    assign face_base = ADDR_WIDTH'(32'd3 * bus.vertex_count + 32'd1);
    assign is_self   = (v_sel == n_sel);
    // While the count word is arriving the register is not loaded yet.
    assign cnt_cur   = (state == S_CNT_RD) ? bus.RAM_NBR_Do : cnt;
    assign room      = (cnt_cur < SLOTS);
    assign match     = (bus.RAM_NBR_Do == n_sel);
    assign last_slot = (slot == cnt);
    assign last_face = (fidx == bus.face_count - 32'd1);

    assign after_face = last_face ? S_DONE : S_FACE_RD;
    assign adv_state  = (dir && edge_sel == 2'd2) ? after_face : S_EDGE;

`ifdef NBR_RANGE_CHECK_EN
    logic bad_r;

    assign face_bad = (va == 32'd0) || (va > bus.vertex_count) ||
                      (vb == 32'd0) || (vb > bus.vertex_count) ||
                      (vc == 32'd0) || (vc > bus.vertex_count);

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            bad_r <= 1'b0;
        else if (state == S_IDLE && bus.start)
            bad_r <= 1'b0;
        else if (state == S_EDGE && face_bad)
            bad_r <= 1'b1;
    end

    assign bus.bad_index = bad_r;
`else
    assign face_bad      = 1'b0;
    assign bus.bad_index = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        nbr_we     = 4'h0;
        do_advance = 1'b0;
        set_ovf    = 1'b0;
        case (state)
            S_IDLE:
                if (bus.start)
                    state_nxt = (bus.vertex_count == 32'd0) ? S_DONE : S_CLEAR;
            S_CLEAR: begin
                nbr_we = 4'hF;
                if (vidx == bus.vertex_count - 32'd1)
                    state_nxt = (bus.face_count == 32'd0) ? S_DONE : S_FACE_RD;
            end
            S_FACE_RD:
                if (sub == 2'd2)
                    state_nxt = S_EDGE;
            S_EDGE:
                if (face_bad)
                    state_nxt = after_face;
                else if (is_self)
                    state_nxt = (edge_sel == 2'd2) ? after_face : S_EDGE;
                else
                    state_nxt = S_CNT_RD;
            S_CNT_RD:
                if (bus.RAM_NBR_Do != 32'd0)
                    state_nxt = S_SCAN_RD;
                else if (room)
                    state_nxt = S_APPEND_WR;
                else begin
                    set_ovf    = 1'b1;
                    do_advance = 1'b1;
                    state_nxt  = adv_state;
                end
            S_SCAN_RD:
                if (match) begin
                    do_advance = 1'b1;
                    state_nxt  = adv_state;
                end else if (last_slot) begin
                    if (room)
                        state_nxt = S_APPEND_WR;
                    else begin
                        set_ovf    = 1'b1;
                        do_advance = 1'b1;
                        state_nxt  = adv_state;
                    end
                end
            S_APPEND_WR: begin
                nbr_we    = 4'hF;
                state_nxt = S_CNT_WR;
            end
            S_CNT_WR: begin
                nbr_we     = 4'hF;
                do_advance = 1'b1;
                state_nxt  = adv_state;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A finished reverse insert or a skipped self-edge moves to the next edge;
    // the third edge (or a rejected face) moves to the next face.
    assign bump_edge = (do_advance && dir) || (state == S_EDGE && !face_bad && is_self);
    assign face_done = (bump_edge && edge_sel == 2'd2) || (state == S_EDGE && face_bad);

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            vidx <= '0; fidx <= '0; cnt <= '0; slot <= '0; wdata <= '0;
            va <= '0; vb <= '0; vc <= '0;
            sub <= '0; edge_sel <= '0; dir <= 1'b0; ovf <= 1'b0;
            addr <= '0; faddr <= '0; base <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (bus.start) begin
                        ovf <= 1'b0; vidx <= '0; fidx <= '0;
                        addr <= '0; wdata <= '0; faddr <= face_base;
                        sub <= '0; edge_sel <= '0; dir <= 1'b0;
                    end
                S_CLEAR: begin
                    vidx <= vidx + 32'd1;
                    addr <= addr + MAX_A;
                end
                // Read data for this cycle's address is valid at its closing edge.
                S_FACE_RD: begin
                    case (sub)
                        2'd0:    va <= bus.RAM_OBJ_Do;
                        2'd1:    vb <= bus.RAM_OBJ_Do;
                        default: vc <= bus.RAM_OBJ_Do;
                    endcase
                    faddr <= faddr + 1'b1;
                    sub   <= (sub == 2'd2) ? 2'd0 : sub + 2'd1;
                end
                S_EDGE:
                    if (!face_bad && !is_self) begin
                        base <= base_nxt;
                        addr <= base_nxt;
                    end
                // An empty block appends at base+1, the same address the scan starts at.
                S_CNT_RD: begin
                    cnt   <= bus.RAM_NBR_Do;
                    slot  <= 32'd1;
                    addr  <= base + 1'b1;
                    wdata <= n_sel;
                end
                S_SCAN_RD:
                    if (!match && !last_slot) begin
                        slot <= slot + 32'd1;
                        addr <= addr + 1'b1;
                    end else if (!match && room) begin
                        addr <= base + ADDR_WIDTH'(cnt + 32'd1);
                    end
                S_APPEND_WR: begin
                    addr  <= base;
                    wdata <= cnt + 32'd1;
                end
                default: ;
            endcase
            if (set_ovf)
                ovf <= 1'b1;
            if (do_advance && !dir)
                dir <= 1'b1;
            if (bump_edge) begin
                dir      <= 1'b0;
                edge_sel <= (edge_sel == 2'd2) ? 2'd0 : edge_sel + 2'd1;
            end
            if (face_done) begin
                fidx     <= fidx + 32'd1;
                edge_sel <= 2'd0;
                dir      <= 1'b0;
            end
        end
    end

    assign bus.busy       = (state != S_IDLE) && (state != S_DONE);
    assign bus.overflow   = ovf;
    assign bus.RAM_OBJ_EN = bus.busy;
    assign bus.RAM_OBJ_WE = 4'h0;
    assign bus.RAM_OBJ_A  = faddr;
    assign bus.RAM_OBJ_Di = 32'd0;
    assign bus.RAM_NBR_EN = bus.busy;
    assign bus.RAM_NBR_WE = nbr_we;
    assign bus.RAM_NBR_A  = addr;
    assign bus.RAM_NBR_Di = wdata;
endmodule

// File: tb/tb_neighbor_builder.sv
// ---------------------------------------------------------------------------
// tb_neighbor_builder
// Self-checking bench: both RAMs are modelled here, meshes are loaded into
// the object RAM, and the finished neighbour table is compared against a
// queue-style reference built directly from the face list.
// ---------------------------------------------------------------------------
module tb_neighbor_builder;
    localparam int MAX   = 10;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neighbor_builder_if #(.ADDR_WIDTH(AW)) bus ();

    neighbor_builder #(.MAX_NEIGHBOR_COUNT(MAX), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] obj_mem [DEPTH];
    logic [31:0] nbr_mem [DEPTH];

    // Synchronous RAMs, read-before-write, sampling on the rising edge.
    always @(posedge clk) begin
        if (bus.RAM_OBJ_EN)
            bus.RAM_OBJ_Do <= obj_mem[bus.RAM_OBJ_A];
        if (bus.RAM_NBR_EN) begin
            if (bus.RAM_NBR_WE == 4'hF)
                nbr_mem[bus.RAM_NBR_A] <= bus.RAM_NBR_Di;
            bus.RAM_NBR_Do <= nbr_mem[bus.RAM_NBR_A];
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Mesh under test and reference table
    int nv, nf;
    int fa [64];
    int fb [64];
    int fc [64];
    int exp_c [64];
    int exp_n [64][16];
    bit exp_ovf, exp_bad;

    function automatic void m_ins(int v, int n);
        for (int i = 0; i < exp_c[v-1]; i++)
            if (exp_n[v-1][i] == n) return;
        if (exp_c[v-1] < MAX - 1) begin
            exp_n[v-1][exp_c[v-1]] = n;
            exp_c[v-1]++;
        end else begin
            exp_ovf = 1'b1;
        end
    endfunction

    function automatic void m_edge(int x, int y);
        if (x != y) begin
            m_ins(x, y);
            m_ins(y, x);
        end
    endfunction

    function automatic void model_run();
        for (int v = 0; v < 64; v++) exp_c[v] = 0;
        exp_ovf = 1'b0;
        exp_bad = 1'b0;
        for (int f = 0; f < nf; f++) begin
`ifdef NBR_RANGE_CHECK_EN
            if (fa[f] < 1 || fa[f] > nv || fb[f] < 1 || fb[f] > nv || fc[f] < 1 || fc[f] > nv) begin
                exp_bad = 1'b1;
                continue;
            end
`endif
            m_edge(fa[f], fb[f]);
            m_edge(fb[f], fc[f]);
            m_edge(fc[f], fa[f]);
        end
    endfunction

    task automatic load_mesh();
        obj_mem[0] = nv;
        for (int i = 1; i <= 3 * nv; i++) obj_mem[i] = $urandom;
        for (int f = 0; f < nf; f++) begin
            obj_mem[3*nv + 1 + 3*f]     = fa[f];
            obj_mem[3*nv + 1 + 3*f + 1] = fb[f];
            obj_mem[3*nv + 1 + 3*f + 2] = fc[f];
        end
        model_run();
    endtask

    task automatic rand_mesh(input int vmin, input int vmax, input int fmax, input bit allow_bad);
        nv = $urandom_range(vmax, vmin);
        nf = $urandom_range(fmax, 1);
        for (int f = 0; f < nf; f++) begin
            fa[f] = $urandom_range(nv, 1);
            fb[f] = $urandom_range(nv, 1);
            fc[f] = $urandom_range(nv, 1);
            if (allow_bad && $urandom_range(7, 0) == 0)
                fb[f] = ($urandom_range(1, 0) == 0) ? 0 : nv + $urandom_range(3, 1);
        end
        load_mesh();
    endtask

    task automatic run_build(input int poke_at, output int cycles);
        logic seen;
        bus.vertex_count = nv;
        bus.face_count   = nf;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        cycles = 1;
        seen = bus.busy;
        while (bus.busy && cycles < LIMIT) begin
            bus.start = (cycles == poke_at);
            @(posedge clk); #1;
            cycles++;
        end
        bus.start = 1'b0;
        chk("build_timeout", 32'(cycles < LIMIT), 32'd1);
        if (nv > 0)
            chk("busy_rise", 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic compare_table(input string tag);
        for (int v = 0; v < nv; v++) begin
            chk($sformatf("%s cnt v%0d", tag, v), nbr_mem[v*MAX], exp_c[v]);
            for (int i = 0; i < exp_c[v]; i++)
                chk($sformatf("%s nbr v%0d s%0d", tag, v, i+1), nbr_mem[v*MAX + 1 + i], exp_n[v][i]);
        end
        chk({tag, " overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        chk({tag, " bad_index"}, 32'(bus.bad_index), 32'(exp_bad));
        chk({tag, " busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    // Per-cycle compare process: bus-level rules that must hold every cycle.
    always @(posedge clk) begin
        if (!rst) begin
            chk("obj_read_only", {bus.RAM_OBJ_WE, bus.RAM_OBJ_Di[27:0]}, 32'd0);
            if (!bus.busy)
                chk("idle_quiet", {bus.RAM_NBR_EN, bus.RAM_NBR_WE, bus.RAM_OBJ_EN}, 32'd0);
            else if (bus.RAM_NBR_WE != 4'h0)
                chk("nbr_write_ok",
                    32'((bus.RAM_NBR_WE == 4'hF) && (int'(bus.RAM_NBR_A) < nv * MAX) &&
                        ((int'(bus.RAM_NBR_A) % MAX == 0) ||
                         (bus.RAM_NBR_Di >= 1 && int'(bus.RAM_NBR_Di) <= nv))),
                    32'd1);
        end
    end

    int c1, c2;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.vertex_count = 0;
        bus.face_count = 0;
        nv = 0;
        nf = 0;
        for (int i = 0; i < DEPTH; i++) obj_mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst flags", {bus.overflow, bus.bad_index}, 0);
        chk("rst en_we", {bus.RAM_NBR_EN, bus.RAM_NBR_WE, bus.RAM_OBJ_EN, bus.RAM_OBJ_WE}, 0);
        chk("rst nbr_a", 32'(bus.RAM_NBR_A), 0);
        chk("rst nbr_di", bus.RAM_NBR_Di, 0);
        chk("rst obj_a", 32'(bus.RAM_OBJ_A), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst busy", 32'(bus.busy), 0);

        // Single triangle
        nv = 3; nf = 1; fa[0] = 1; fb[0] = 2; fc[0] = 3;
        load_mesh();
        chk("model tri cnt0", exp_c[0], 2);
        chk("model tri v2s1", exp_n[1][0], 1);
        run_build(0, c1);
        compare_table("tri");
        chk("tri NBR0", nbr_mem[0], 2);  chk("tri NBR1", nbr_mem[1], 2);  chk("tri NBR2", nbr_mem[2], 3);
        chk("tri NBR10", nbr_mem[10], 2); chk("tri NBR11", nbr_mem[11], 1); chk("tri NBR12", nbr_mem[12], 3);
        chk("tri NBR20", nbr_mem[20], 2); chk("tri NBR21", nbr_mem[21], 2); chk("tri NBR22", nbr_mem[22], 1);

        // Two triangles sharing edge 1-3
        nv = 4; nf = 2;
        fa[0] = 1; fb[0] = 2; fc[0] = 3;
        fa[1] = 1; fb[1] = 3; fc[1] = 4;
        load_mesh();
        run_build(0, c1);
        compare_table("quad");
        chk("quad NBR0", nbr_mem[0], 3); chk("quad NBR1", nbr_mem[1], 2);
        chk("quad NBR2", nbr_mem[2], 3); chk("quad NBR3", nbr_mem[3], 4);
        chk("quad NBR20", nbr_mem[20], 3); chk("quad NBR21", nbr_mem[21], 2);
        chk("quad NBR22", nbr_mem[22], 1); chk("quad NBR23", nbr_mem[23], 4);

        // Fan of 10 faces around vertex 1: 11 neighbours into 9 slots
        nv = 12; nf = 10;
        for (int f = 0; f < 10; f++) begin fa[f] = 1; fb[f] = f + 2; fc[f] = f + 3; end
        load_mesh();
        chk("model fan ovf", 32'(exp_ovf), 1);
        run_build(0, c1);
        compare_table("fan");
        chk("fan NBR0", nbr_mem[0], 9);
        chk("fan NBR9", nbr_mem[9], 10);
        chk("fan overflow", 32'(bus.overflow), 1);

        // No vertices, then vertices with no faces
        nv = 0; nf = 3;
        load_mesh();
        run_build(0, c1);
        chk("v0 busy", 32'(bus.busy), 0);
        chk("v0 quick", 32'(c1 <= 2), 1);
        nv = 5; nf = 0;
        load_mesh();
        run_build(0, c1);
        compare_table("f0");

        // start pulse while busy must not restart or lengthen the build
        rand_mesh(8, 14, 10, 1'b0);
        run_build(0, c1);
        compare_table("poke_ref");
        run_build(c1 / 2, c2);
        compare_table("poke");
        chk("poke_len", c2, c1);

        // Reset in the middle of a build, while the slot scan is running
        rand_mesh(10, 16, 12, 1'b0);
        bus.vertex_count = nv;
        bus.face_count   = nf;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n > nv + 6 && bus.busy && bus.RAM_NBR_WE == 4'h0 && (int'(bus.RAM_NBR_A) % MAX) != 0)
                break;
            @(posedge clk); #1;
        end
        chk("midrst busy_before", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(bus.busy), 0);
        chk("midrst we", 32'(bus.RAM_NBR_WE), 0);
        chk("midrst a", 32'(bus.RAM_NBR_A), 0);
        chk("midrst en", {bus.RAM_NBR_EN, bus.RAM_OBJ_EN}, 0);
        @(posedge clk); #1 rst = 1'b0;
        run_build(0, c1);
        compare_table("after_rst");

`ifdef NBR_RANGE_CHECK_EN
        nv = 3; nf = 1; fa[0] = 1; fb[0] = 2; fc[0] = 9;
        load_mesh();
        run_build(0, c1);
        compare_table("range");
        chk("range bad_index", 32'(bus.bad_index), 1);
        chk("range NBR0", nbr_mem[0], 0);
`endif

        // Random meshes
        for (int t = 0; t < 10; t++) begin
`ifdef NBR_RANGE_CHECK_EN
            rand_mesh(2, 16, 12, 1'b1);
`else
            rand_mesh(2, 16, 12, 1'b0);
`endif
            run_build(0, c1);
            compare_table($sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
